int_flag_ctrl: RTL and testbench

Interrupt and flag-shadow controller for the RAT CPU. It sits between the control unit and the C/Z flag registers. It detects and holds external interrupt requests, owns the interrupt-enable flag (I), and captures C and Z into shadow registers when an interrupt is taken. On return-from-interrupt it drives the shadow values and a load strobe back into the flag registers' input muxes.

---
 rtl/int_flag_ctrl.sv | 120 ++++++++++++
 tb/tb_int_flag_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_flag_ctrl.sv
// int_flag_ctrl: RAT CPU interrupt request detect/hold, interrupt-enable flag and C/Z shadows.
// Optional `INT_SYNC_EN adds a two-flop synchronizer on INTR ahead of the edge detector.
module int_flag_ctrl (
    input  logic clk,
    input  logic RST,
    input  logic INTR,
    input  logic I_SET,
    input  logic I_CLEAR,
    input  logic INT_ACK,
    input  logic RETI,
    input  logic RETI_IE,
    input  logic C_FLAG,
    input  logic Z_FLAG,
    output logic INT_REQ,
    output logic I_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic FLG_SHAD_LD
);

    typedef enum logic [1:0] {StIdle, StPend, StService} state_e;

    state_e state_q, state_d;
    logic   late_pend_q, late_pend_d;
    logic   i_flag_q, i_flag_d;
    logic   shad_c_q, shad_z_q;
    logic   prev_q;
    logic   intr_edge;
    logic   ack_ok;

`ifdef INT_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= INTR;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign intr_edge = sync2_q & ~prev_q;
`else
    always_ff @(posedge clk) begin
        if (RST) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= INTR;
        end
    end

    assign intr_edge = INTR & ~prev_q;
`endif

    assign INT_REQ     = (state_q == StPend) & i_flag_q;
    // RETI in the same cycle blocks the acknowledge so return always wins
    assign ack_ok      = INT_ACK & INT_REQ & ~RETI;
    assign FLG_SHAD_LD = RETI;
    assign I_FLAG      = i_flag_q;
    assign SHAD_C      = shad_c_q;
    assign SHAD_Z      = shad_z_q;

    always_comb begin
        state_d     = state_q;
        late_pend_d = late_pend_q;
        unique case (state_q)
            StIdle: begin
                if (intr_edge) state_d = StPend;
            end
            StPend: begin
                if (ack_ok) state_d = StService;
            end
            StService: begin
                if (RETI) begin
                    state_d     = (late_pend_q || intr_edge) ? StPend : StIdle;
                    late_pend_d = 1'b0;
                end else if (intr_edge) begin
                    late_pend_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        i_flag_d = i_flag_q;
        if (ack_ok) begin
            i_flag_d = 1'b0;
        end else if (RETI) begin
            i_flag_d = RETI_IE;
        end else if (I_CLEAR) begin
            i_flag_d = 1'b0;
        end else if (I_SET) begin
            i_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= StIdle;
            late_pend_q <= 1'b0;
            i_flag_q    <= 1'b0;
            shad_c_q    <= 1'b0;
            shad_z_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            late_pend_q <= late_pend_d;
            i_flag_q    <= i_flag_d;
            if (ack_ok) begin
                shad_c_q <= C_FLAG;
                shad_z_q <= Z_FLAG;
            end
        end
    end

endmodule

// File: tb/tb_int_flag_ctrl.sv
// Scoreboard bench for int_flag_ctrl: expectations queued as stimulus is driven,
// compared against the DUT outputs on the falling edge of the same cycle.
module tb_int_flag_ctrl;

`ifdef INT_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    localparam int OReq = 4;
    localparam int OI   = 3;
    localparam int OC   = 2;
    localparam int OZ   = 1;
    localparam int OLd  = 0;

    logic clk = 1'b0;
    logic RST, INTR, I_SET, I_CLEAR, INT_ACK, RETI, RETI_IE, C_FLAG, Z_FLAG;
    logic INT_REQ, I_FLAG, SHAD_C, SHAD_Z, FLG_SHAD_LD;
    logic [4:0] outs;

    typedef struct {
        string tag;
        int    idx;
        logic  v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    int_flag_ctrl dut (
        .clk        (clk),
        .RST        (RST),
        .INTR       (INTR),
        .I_SET      (I_SET),
        .I_CLEAR    (I_CLEAR),
        .INT_ACK    (INT_ACK),
        .RETI       (RETI),
        .RETI_IE    (RETI_IE),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG),
        .INT_REQ    (INT_REQ),
        .I_FLAG     (I_FLAG),
        .SHAD_C     (SHAD_C),
        .SHAD_Z     (SHAD_Z),
        .FLG_SHAD_LD(FLG_SHAD_LD)
    );

    assign outs = {INT_REQ, I_FLAG, SHAD_C, SHAD_Z, FLG_SHAD_LD};

    task automatic check_eq(input string tag, input logic obs, input logic exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_exp(input string tag, input int idx, input logic v);
        exp_t e;
        e.tag = tag;
        e.idx = idx;
        e.v   = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq(e.tag, outs[e.idx], e.v);
        end
    end

    // Advance one cycle; strobes are single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        I_SET   = 1'b0;
        I_CLEAR = 1'b0;
        INT_ACK = 1'b0;
        RETI    = 1'b0;
    endtask

    task automatic push_reset_vals(input string tag);
        push_exp({tag, "_req"}, OReq, 1'b0);
        push_exp({tag, "_i"},   OI,   1'b0);
        push_exp({tag, "_c"},   OC,   1'b0);
        push_exp({tag, "_z"},   OZ,   1'b0);
        push_exp({tag, "_ld"},  OLd,  1'b0);
    endtask

    // One-cycle INTR pulse; INT_REQ expected after Lat+1 cycles (I_FLAG assumed 1).
    task automatic raise_req();
        INTR = 1'b1;
        push_exp("req_lat", OReq, 1'b0);
        tick();
        INTR = 1'b0;
        for (int i = 0; i < Lat; i++) begin
            push_exp("req_lat", OReq, 1'b0);
            tick();
        end
        push_exp("req_rise", OReq, 1'b1);
    endtask

    task automatic take_int(input logic c, input logic z);
        C_FLAG  = c;
        Z_FLAG  = z;
        INT_ACK = 1'b1;
        tick();
        push_exp("ack_c",   OC,   c);
        push_exp("ack_z",   OZ,   z);
        push_exp("ack_i",   OI,   1'b0);
        push_exp("ack_req", OReq, 1'b0);
    endtask

    initial begin
        RST = 1'b1; INTR = 1'b0; I_SET = 1'b0; I_CLEAR = 1'b0; INT_ACK = 1'b0;
        RETI = 1'b0; RETI_IE = 1'b0; C_FLAG = 1'b0; Z_FLAG = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        push_reset_vals("reset");

        // Basic request with INTR held high
        I_SET = 1'b1;
        tick();
        push_exp("iset", OI, 1'b1);
        INTR = 1'b1;
        for (int i = 0; i <= Lat; i++) begin
            push_exp("basic_lat", OReq, 1'b0);
            tick();
        end
        push_exp("basic_rise", OReq, 1'b1);
        tick();
        push_exp("basic_hold", OReq, 1'b1);

        // Interrupt entry, then shadows hold while live flags change
        take_int(1'b1, 1'b0);
        C_FLAG = 1'b0;
        Z_FLAG = 1'b1;
        tick();
        push_exp("shad_hold_c", OC, 1'b1);
        push_exp("shad_hold_z", OZ, 1'b0);

        // RETIE
        RETI = 1'b1;
        RETI_IE = 1'b1;
        push_exp("retie_ld", OLd, 1'b1);
        push_exp("retie_c",  OC,  1'b1);
        push_exp("retie_z",  OZ,  1'b0);
        tick();
        push_exp("retie_i",   OI,   1'b1);
        push_exp("retie_ld0", OLd,  1'b0);
        push_exp("retie_req", OReq, 1'b0);
        tick();
        push_exp("retie_idle", OReq, 1'b0);

        // RETID
        INTR = 1'b0;
        repeat (Lat + 1) tick();
        raise_req();
        take_int(1'b0, 1'b1);
        RETI = 1'b1;
        RETI_IE = 1'b0;
        push_exp("retid_ld", OLd, 1'b1);
        push_exp("retid_c",  OC,  1'b0);
        push_exp("retid_z",  OZ,  1'b1);
        tick();
        push_exp("retid_i",   OI,   1'b0);
        push_exp("retid_req", OReq, 1'b0);
        I_SET = 1'b1;
        tick();
        push_exp("retid_idle", OReq, 1'b0);

        // Nested edges during service: exactly one request survives
        raise_req();
        take_int(1'b1, 1'b1);
        INTR = 1'b1; tick();
        INTR = 1'b0; tick();
        INTR = 1'b1; tick();
        INTR = 1'b0;
        for (int i = 0; i <= Lat; i++) begin
            push_exp("nest_svc_req", OReq, 1'b0);
            tick();
        end
        RETI = 1'b1;
        RETI_IE = 1'b1;
        tick();
        push_exp("nest_req", OReq, 1'b1);
        tick();
        push_exp("nest_req_hold", OReq, 1'b1);
        take_int(1'b0, 1'b0);
        RETI = 1'b1;
        RETI_IE = 1'b1;
        tick();
        for (int i = 0; i < Lat + 2; i++) begin
            push_exp("nest_idle", OReq, 1'b0);
            tick();
        end

        // I_SET loses to accepted INT_ACK
        raise_req();
        I_SET = 1'b1;
        take_int(1'b1, 1'b0);
        RETI = 1'b1;
        RETI_IE = 1'b0;
        tick();
        push_exp("prio_ret_i", OI, 1'b0);

        // Masked request with a stray INT_ACK, then unmask
        INTR = 1'b1;
        tick();
        INTR = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_exp("masked_req", OReq, 1'b0);
            if (i == 5) begin
                C_FLAG  = 1'b0;
                Z_FLAG  = 1'b1;
                INT_ACK = 1'b1;
            end
            tick();
        end
        push_exp("stray_ack_c", OC, 1'b1);
        push_exp("stray_ack_z", OZ, 1'b0);
        push_exp("stray_ack_i", OI, 1'b0);
        I_SET = 1'b1;
        tick();
        push_exp("unmask_req", OReq, 1'b1);

        // Reset while in service
        take_int(1'b1, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        push_reset_vals("rst_svc");
        I_SET = 1'b1;
        tick();
        for (int i = 0; i < Lat + 2; i++) begin
            push_exp("rst_nopend", OReq, 1'b0);
            tick();
        end

        // I_CLEAR beats I_SET; RETI outside service
        I_SET = 1'b1;
        I_CLEAR = 1'b1;
        tick();
        push_exp("clr_prio", OI, 1'b0);
        RETI = 1'b1;
        RETI_IE = 1'b1;
        I_CLEAR = 1'b1;
        push_exp("stray_reti_ld", OLd, 1'b1);
        tick();
        push_exp("reti_over_clr",    OI,   1'b1);
        push_exp("stray_reti_state", OReq, 1'b0);
        push_exp("stray_reti_c",     OC,   1'b0);
        push_exp("stray_reti_ld0",   OLd,  1'b0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
